pipeline_ctrl: RTL and testbench

Hazard and sequencing controller for the five-stage RV32I pipeline. It drives the stage register enables and flushes around the execute stage, generates registered operand-forwarding selects for the execute ALU, inserts a load-use bubble, freezes the pipeline while data memory is busy, and flushes younger stages on a control-flow redirect. It keeps a shadow pipeline of destination/opcode state for the EX, MEM and WB slots, advanced by the same enables it issues.

---
 rtl/pipeline_ctrl_pkg.sv | 48 ++++
 rtl/pipeline_ctrl_shadow.sv | 33 +++
 rtl/pipeline_ctrl.sv | 120 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants and types for the RV32I hazard/sequencing controller.
// Opcodes, FSM states, forward-select codes and the shadow slot record.
package pipeline_ctrl_pkg;

  localparam int RD_W = 5;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] JAL    = 7'b1101111;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            writes_rd;
    logic            is_load;
  } shadow_t;

  function automatic shadow_t decode_slot(
    input logic            v,
    input logic [6:0]      op,
    input logic [RD_W-1:0] rd
  );
    shadow_t s;
    s           = '0;
    s.valid     = v;
    s.rd        = rd;
    s.writes_rd = v && (op != STORE) &&
                  (op != BRANCH) && (rd != '0);
    s.is_load   = v && (op == LOAD);
    return s;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_shadow.sv
// Three-slot EX/MEM/WB shadow chain of destination/opcode state.
// Advanced by the same enables the controller drives onto the pipeline.
module hazard_shadow
  import pipeline_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    id_ex_en,
  input  logic    id_ex_flush,
  input  logic    ex_mem_en,
  input  logic    mem_wb_en,
  input  shadow_t id_slot,
  output shadow_t ex_slot,
  output shadow_t mem_slot,
  output shadow_t wb_slot
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_slot  <= '0;
      mem_slot <= '0;
      wb_slot  <= '0;
    end else begin
      if (id_ex_en)
        ex_slot <= id_ex_flush ? '0 : id_slot;
      if (ex_mem_en)
        mem_slot <= ex_slot;
      if (mem_wb_en)
        wb_slot <= mem_slot;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage RV32I pipeline.
// Stage enables/flushes, forward selects, load-use and memory stalls.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int XLEN_RD = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [6:0]         id_opcode,
  input  logic [XLEN_RD-1:0] id_rd_num,
  input  logic [XLEN_RD-1:0] id_rs1_num,
  input  logic [XLEN_RD-1:0] id_rs2_num,
  input  logic               ex_redirect,
  input  logic               mem_req,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               if_id_en,
  output logic               id_ex_en,
  output logic               ex_mem_en,
  output logic               mem_wb_en,
  output logic               if_id_flush,
  output logic               id_ex_flush,
  output logic               wb_en,
  output logic [1:0]         fwd_a_sel,
  output logic [1:0]         fwd_b_sel
);

  state_t  state;
  shadow_t id_slot;
  shadow_t ex_s;
  shadow_t mem_s;
  shadow_t wb_s;
  logic    freeze;
  logic    redirect;
  logic    load_use;
  logic    unused_ok;

  assign id_slot = decode_slot(id_valid, id_opcode, id_rd_num);

  hazard_shadow u_shadow (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_ex_en    (id_ex_en),
    .id_ex_flush (id_ex_flush),
    .ex_mem_en   (ex_mem_en),
    .mem_wb_en   (mem_wb_en),
    .id_slot     (id_slot),
    .ex_slot     (ex_s),
    .mem_slot    (mem_s),
    .wb_slot     (wb_s)
  );

  // WB is covered by write-before-read in the register file
  assign unused_ok = ^{wb_s, mem_s.is_load};

  function automatic logic [1:0] pick(
    input logic [XLEN_RD-1:0] rs,
    input shadow_t            ex,
    input shadow_t            mem
  );
    logic ex_hit;
    logic mem_hit;
    ex_hit  = (rs != '0) && ex.valid &&
              ex.writes_rd && (ex.rd == rs);
    mem_hit = (rs != '0) && mem.valid &&
              mem.writes_rd && (mem.rd == rs) &&
              !ex_hit;
    pick = FWD_RF;
    unique case (1'b1)
      ex_hit:  pick = FWD_EXMEM;
      mem_hit: pick = FWD_MEMWB;
      default: pick = FWD_RF;
    endcase
  endfunction

  assign freeze   = (state == MEM_WAIT);
  assign redirect = !freeze && ex_redirect;
  assign load_use = !freeze && !redirect &&
                    id_valid && ex_s.valid &&
                    ex_s.is_load && (ex_s.rd != '0) &&
                    ((ex_s.rd == id_rs1_num) ||
                     (ex_s.rd == id_rs2_num));

  assign pc_en       = !freeze && !load_use;
  assign if_id_en    = !freeze && !load_use;
  assign id_ex_en    = !freeze;
  assign ex_mem_en   = !freeze;
  assign mem_wb_en   = !freeze;
  assign wb_en       = !freeze;
  assign if_id_flush = redirect;
  assign id_ex_flush = redirect || load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
    end else begin
      if (id_ex_en) begin
        fwd_a_sel <= id_ex_flush ? FWD_RF :
                     pick(id_rs1_num, ex_s, mem_s);
        fwd_b_sel <= id_ex_flush ? FWD_RF :
                     pick(id_rs2_num, ex_s, mem_s);
      end
      unique case (state)
        RUN:
          if (mem_req && !mem_ready && mem_s.valid)
            state <= MEM_WAIT;
        MEM_WAIT:
          if (mem_ready)
            state <= RUN;
        default:
          state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus a
// randomized run against an instruction-history reference model.
module tb_pipeline_ctrl;

  localparam bit [6:0] LD  = 7'b0000011;
  localparam bit [6:0] IMM = 7'b0010011;
  localparam bit [6:0] ALU = 7'b0110011;
  localparam bit [6:0] ST  = 7'b0100011;
  localparam bit [6:0] BR  = 7'b1100011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [6:0] id_opcode;
  logic [4:0] id_rd_num;
  logic [4:0] id_rs1_num;
  logic [4:0] id_rs2_num;
  logic       ex_redirect;
  logic       mem_req;
  logic       mem_ready;
  logic       pc_en;
  logic       if_id_en;
  logic       id_ex_en;
  logic       ex_mem_en;
  logic       mem_wb_en;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       wb_en;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;

  int passed = 0;
  int total  = 0;

  pipeline_ctrl #(.XLEN_RD(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_opcode   (id_opcode),
    .id_rd_num   (id_rd_num),
    .id_rs1_num  (id_rs1_num),
    .id_rs2_num  (id_rs2_num),
    .ex_redirect (ex_redirect),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .pc_en       (pc_en),
    .if_id_en    (if_id_en),
    .id_ex_en    (id_ex_en),
    .ex_mem_en   (ex_mem_en),
    .mem_wb_en   (mem_wb_en),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .wb_en       (wb_en),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel)
  );

  always #5 clk = ~clk;

  wire [5:0] en = {pc_en, if_id_en, id_ex_en,
                   ex_mem_en, mem_wb_en, wb_en};
  wire [1:0] fl = {if_id_flush, id_ex_flush};

  // Reference model: ordered history of what entered EX.
  // Newest entry is in EX, the one before it in MEM.
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       wr;
    bit       ld;
  } ins_t;

  ins_t     hist[$];
  bit       m_wait;
  bit [1:0] m_sa;
  bit [1:0] m_sb;

  function automatic ins_t mk(bit v, bit [6:0] op, bit [4:0] rd);
    ins_t n;
    n.v  = v;
    n.rd = rd;
    n.wr = v && op != ST && op != BR && rd != 0;
    n.ld = v && op == LD;
    return n;
  endfunction

  function automatic bit [1:0] nearest(bit [4:0] rs);
    if (rs == 0) return 2'd0;
    for (int d = 1; d <= 2; d++) begin
      ins_t e;
      e = hist[hist.size() - d];
      if (e.v && e.wr && e.rd == rs) return d[1:0];
    end
    return 2'd0;
  endfunction

  function automatic bit m_lu();
    ins_t e;
    e = hist[hist.size() - 1];
    return id_valid && e.v && e.ld && e.rd != 0 &&
           (e.rd == id_rs1_num || e.rd == id_rs2_num);
  endfunction

  function automatic bit [11:0] m_exp();
    bit red;
    bit lu;
    red = !m_wait && ex_redirect;
    lu  = !m_wait && !red && m_lu();
    if (m_wait) return {6'b0, 2'b0, m_sa, m_sb};
    return {!lu, !lu, 4'b1111, red, red || lu, m_sa, m_sb};
  endfunction

  task automatic model_reset();
    ins_t b;
    b = '{default: 0};
    hist.delete();
    repeat (3) hist.push_back(b);
    m_wait = 0;
    m_sa   = 0;
    m_sb   = 0;
  endtask

  task automatic model_advance();
    bit   frz;
    bit   red;
    bit   lu;
    bit   mem_v;
    ins_t n;
    if (!rst_n) begin
      model_reset();
      return;
    end
    frz   = m_wait;
    red   = !frz && ex_redirect;
    lu    = !frz && !red && m_lu();
    mem_v = hist[hist.size() - 2].v;
    if (!frz) begin
      m_sa = (red || lu) ? 2'd0 : nearest(id_rs1_num);
      m_sb = (red || lu) ? 2'd0 : nearest(id_rs2_num);
      n = (red || lu) ? '{default: 0} :
          mk(id_valid, id_opcode, id_rd_num);
      hist.push_back(n);
      void'(hist.pop_front());
    end
    m_wait = frz ? !mem_ready : (mem_req && !mem_ready && mem_v);
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(bit v, bit [6:0] op, bit [4:0] rd,
                        bit [4:0] r1, bit [4:0] r2);
    id_valid   = v;
    id_opcode  = op;
    id_rd_num  = rd;
    id_rs1_num = r1;
    id_rs2_num = r2;
    #1;
  endtask

  task automatic idle();
    ex_redirect = 0;
    mem_req     = 0;
    mem_ready   = 1;
    set_id(0, IMM, 0, 0, 0);
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    model_reset();
    total++;
    if (en !== 6'b111111)
      $display("FAIL reset_en got %b want 111111", en);
    else passed++;
    total++;
    if (fl !== 2'b00)
      $display("FAIL reset_flush got %b want 00", fl);
    else passed++;
    total++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0)
      $display("FAIL reset_fwd got %0d/%0d want 0/0",
               fwd_a_sel, fwd_b_sel);
    else passed++;
    tick();
    tick();
    rst_n = 1;
    #1;
  endtask

  task automatic test_fwd_ex();
    drain();
    set_id(1, IMM, 1, 0, 5);
    tick();
    set_id(1, ALU, 2, 1, 1);
    total++;
    if (en !== 6'b111111 || fl !== 2'b00)
      $display("FAIL fwd_ex_nostall got %b/%b want 111111/00",
               en, fl);
    else passed++;
    tick();
    idle();
    total++;
    if (fwd_a_sel !== 2'd1 || fwd_b_sel !== 2'd1)
      $display("FAIL fwd_ex got %0d/%0d want 1/1",
               fwd_a_sel, fwd_b_sel);
    else passed++;
    tick();
  endtask

  task automatic test_fwd_mem();
    drain();
    set_id(1, IMM, 1, 0, 5);
    tick();
    set_id(0, IMM, 0, 0, 0);
    tick();
    set_id(1, ALU, 3, 1, 0);
    tick();
    idle();
    total++;
    if (fwd_a_sel !== 2'd2 || fwd_b_sel !== 2'd0)
      $display("FAIL fwd_mem got %0d/%0d want 2/0",
               fwd_a_sel, fwd_b_sel);
    else passed++;
    tick();
  endtask

  task automatic test_load_use();
    drain();
    set_id(1, LD, 5, 1, 0);
    tick();
    set_id(1, ALU, 6, 5, 7);
    total++;
    if (en !== 6'b001111 || fl !== 2'b01)
      $display("FAIL load_use_bubble got %b/%b want 001111/01",
               en, fl);
    else passed++;
    tick();
    total++;
    if (en !== 6'b111111 || fl !== 2'b00)
      $display("FAIL load_use_once got %b/%b want 111111/00",
               en, fl);
    else passed++;
    tick();
    idle();
    total++;
    if (fwd_a_sel !== 2'd2 || fwd_b_sel !== 2'd0)
      $display("FAIL load_use_fwd got %0d/%0d want 2/0",
               fwd_a_sel, fwd_b_sel);
    else passed++;
    tick();
  endtask

  task automatic test_x0();
    drain();
    set_id(1, LD, 0, 1, 0);
    tick();
    set_id(1, ALU, 3, 0, 0);
    total++;
    if (en !== 6'b111111 || fl !== 2'b00)
      $display("FAIL x0_nostall got %b/%b want 111111/00",
               en, fl);
    else passed++;
    tick();
    idle();
    total++;
    if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0)
      $display("FAIL x0_fwd got %0d/%0d want 0/0",
               fwd_a_sel, fwd_b_sel);
    else passed++;
    tick();
  endtask

  task automatic test_mem_stall();
    drain();
    set_id(1, LD, 5, 1, 0);
    tick();
    idle();
    tick();
    mem_req   = 1;
    mem_ready = 0;
    #1;
    total++;
    if (en !== 6'b111111)
      $display("FAIL stall_entry got %b want 111111", en);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) begin
        mem_ready = 1;
        #1;
      end
      total++;
      if (en !== 6'b000000 || fl !== 2'b00)
        $display("FAIL stall_cyc%0d got %b/%b want 000000/00",
                 i, en, fl);
      else passed++;
    end
    tick();
    mem_req = 0;
    #1;
    total++;
    if (en !== 6'b111111)
      $display("FAIL stall_release got %b want 111111", en);
    else passed++;
    tick();
  endtask

  task automatic test_redirect_freeze_reset();
    drain();
    set_id(1, LD, 9, 1, 0);
    tick();
    idle();
    tick();
    mem_req   = 1;
    mem_ready = 0;
    #1;
    tick();
    ex_redirect = 1;
    #1;
    total++;
    if (fl !== 2'b00 || en !== 6'b0)
      $display("FAIL redir_frozen got %b/%b want 00/000000",
               fl, en);
    else passed++;
    tick();
    mem_ready = 1;
    #1;
    total++;
    if (fl !== 2'b00)
      $display("FAIL redir_release got %b want 00", fl);
    else passed++;
    tick();
    mem_req = 0;
    #1;
    total++;
    if (fl !== 2'b11 || en !== 6'b111111)
      $display("FAIL redir_applied got %b/%b want 11/111111",
               fl, en);
    else passed++;
    tick();
    idle();
    set_id(1, LD, 9, 1, 0);
    tick();
    set_id(1, IMM, 1, 0, 5);
    tick();
    set_id(1, ALU, 2, 1, 1);
    mem_req   = 1;
    mem_ready = 0;
    #1;
    tick();
    set_id(0, IMM, 0, 0, 0);
    total++;
    if (en !== 6'b0 || fwd_a_sel !== 2'd1)
      $display("FAIL stall2_hold got %b/%0d want 000000/1",
               en, fwd_a_sel);
    else passed++;
    rst_n = 0;
    #1;
    total++;
    if (en !== 6'b111111 || fl !== 2'b00)
      $display("FAIL midreset_en got %b/%b want 111111/00",
               en, fl);
    else passed++;
    total++;
    if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0)
      $display("FAIL midreset_fwd got %0d/%0d want 0/0",
               fwd_a_sel, fwd_b_sel);
    else passed++;
    tick();
    rst_n = 1;
    idle();
  endtask

  task automatic test_random();
    bit [6:0]  ops [9];
    bit [11:0] exp;
    bit [11:0] got;
    ops = '{LD, IMM, ALU, ST, BR, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111};
    rst_n = 0;
    idle();
    tick();
    rst_n = 1;
    #1;
    for (int c = 0; c < 400; c++) begin
      ex_redirect = ($urandom_range(0, 9) == 0);
      mem_req     = $urandom_range(0, 1) != 0;
      mem_ready   = ($urandom_range(0, 2) != 0);
      set_id($urandom_range(0, 3) != 0,
             ops[$urandom_range(0, 8)],
             5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)));
      exp = m_exp();
      got = {en, fl, fwd_a_sel, fwd_b_sel};
      total++;
      if (got !== exp)
        $display("FAIL random_c%0d got %b want %b", c, got, exp);
      else passed++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fwd_ex();
    test_fwd_mem();
    test_load_use();
    test_x0();
    test_mem_stall();
    test_redirect_freeze_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
